// File: rtl/bus_pkg.sv
// Shared types for the system-bus arbiter: FSM state encoding and default sizing.
package bus_pkg;

    localparam int N_MASTERS_DEFAULT = 2;
    localparam int IDX_W_DEFAULT     = $clog2(N_MASTERS_DEFAULT);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    typedef logic [IDX_W_DEFAULT-1:0] master_idx_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        logic [IDX_W:0] cand;
        valid = |req;
        idx   = '0;
        cand  = '0;
        // Scan from the farthest offset down so the nearest request to ptr wins.
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(N))
                cand = cand - (IDX_W + 1)'(N);
            if (req[cand[IDX_W-1:0]])
                idx = cand[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Central bus arbiter: round-robin grant, one-slot split parking and prioritised resume.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEFAULT,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_MASTERS-1:0] breq,
    output logic [N_MASTERS-1:0] bgrant,
    output logic [N_MASTERS-1:0] split,
    output logic [IDX_W-1:0]     msel,
    output logic                 bus_busy,
    input  logic                 split_req,
    input  logic                 split_release,
    output logic                 split_busy
);

    localparam logic [N_MASTERS-1:0] ONE_HOT0 = N_MASTERS'(1);

    arb_state_t             state_reg;
    logic [IDX_W-1:0]       rr_ptr_reg;
    logic [IDX_W-1:0]       split_owner_reg;
    logic [IDX_W-1:0]       resume_idx_reg;
    logic                   resume_pend_reg;

    logic [N_MASTERS-1:0]   eligible;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   release_ok;
    logic                   park_ok;
    logic [N_MASTERS-1:0]   split_next;
    logic                   split_busy_next;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == N_MASTERS - 1) ? '0 : i + 1'b1;
    endfunction

    assign eligible = breq & ~split;

    rr_picker #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (eligible),
        .ptr   (rr_ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A release frees the slot in the same cycle, so a coincident split_req can take it.
    assign release_ok = split_release & split_busy;
    assign park_ok    = (state_reg == OWNED) & split_req & breq[msel]
                      & (~split_busy | release_ok);

    always_comb begin
        split_next      = split;
        split_busy_next = split_busy;
        if (release_ok) begin
            split_next[split_owner_reg] = 1'b0;
            split_busy_next             = 1'b0;
        end
        if (park_ok) begin
            split_next[msel] = 1'b1;
            split_busy_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            bgrant          <= '0;
            split           <= '0;
            msel            <= '0;
            bus_busy        <= 1'b0;
            split_busy      <= 1'b0;
            rr_ptr_reg      <= '0;
            split_owner_reg <= '0;
            resume_idx_reg  <= '0;
            resume_pend_reg <= 1'b0;
        end else begin
            split      <= split_next;
            split_busy <= split_busy_next;

            case (state_reg)
                IDLE: begin
                    if (resume_pend_reg && breq[resume_idx_reg]) begin
                        bgrant          <= ONE_HOT0 << resume_idx_reg;
                        msel            <= resume_idx_reg;
                        bus_busy        <= 1'b1;
                        resume_pend_reg <= 1'b0;
                        state_reg       <= OWNED;
                    end else begin
                        // A resume whose master no longer requests is simply dropped.
                        resume_pend_reg <= 1'b0;
                        if (pick_valid) begin
                            bgrant    <= ONE_HOT0 << pick_idx;
                            msel      <= pick_idx;
                            bus_busy  <= 1'b1;
                            state_reg <= OWNED;
                        end
                    end
                end
                OWNED: begin
                    if (!breq[msel] || park_ok) begin
                        bgrant     <= '0;
                        bus_busy   <= 1'b0;
                        rr_ptr_reg <= next_idx(msel);
                        state_reg  <= IDLE;
                    end
                    if (park_ok)
                        split_owner_reg <= msel;
                end
                default: state_reg <= IDLE;
            endcase

            // Placed last so a fresh release wins over the IDLE-path clear.
            if (release_ok) begin
                resume_pend_reg <= 1'b1;
                resume_idx_reg  <= split_owner_reg;
            end
        end
    end

endmodule
